// File: rtl/seq_shift_unit_if.sv
// Start/done handshake bundle between the control unit (master) and seq_shift_unit (slave).
interface seq_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [31:0]      shiftBy;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, operand, shiftBy,
        input  result, busy, done, err
    );

    modport slave (
        input  start, op, operand, shiftBy,
        output result, busy, done, err
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Iterative shift/rotate engine: one bit position per clock, start/done handshake.
// Define SEQ_SHIFT_ROTATE_EN to build ROR/ROL; otherwise those op codes are flagged illegal.
module seq_shift_unit #(
    parameter int WIDTH    = 32,
    parameter int AMT_BITS = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    seq_shift_unit_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
`endif

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    step_val;
    logic [2:0]          op_q, op_d;
    logic [AMT_BITS-1:0] count_q, count_d;
    logic                err_q, err_d;
    logic                accept;
    logic                op_legal;
    logic [AMT_BITS-1:0] amt_in;
    logic                unused_shift_hi;

    assign amt_in          = bus.shiftBy[AMT_BITS-1:0];
    assign unused_shift_hi = ^bus.shiftBy[31:AMT_BITS];

`ifdef SEQ_SHIFT_ROTATE_EN
    assign op_legal = (bus.op <= OP_ROL);
`else
    assign op_legal = (bus.op <= OP_SHL);
`endif

    assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // One-bit step; only legal ops ever reach SHIFT, so the default is unreachable.
    always_comb begin
        step_val = result_q;
        case (op_q)
            OP_SHR:  step_val = {1'b0, result_q[WIDTH-1:1]};
            OP_SHRA: step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            OP_SHL:  step_val = {result_q[WIDTH-2:0], 1'b0};
`ifdef SEQ_SHIFT_ROTATE_EN
            OP_ROR:  step_val = {result_q[0], result_q[WIDTH-1:1]};
            OP_ROL:  step_val = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
`endif
            default: step_val = result_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        count_d  = count_q;
        err_d    = err_q;
        if (accept) begin
            result_d = bus.operand;
            op_d     = bus.op;
            count_d  = amt_in;
            err_d    = !op_legal;
            state_d  = (op_legal && (amt_in != '0)) ? S_SHIFT : S_DONE;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    result_d = step_val;
                    count_d  = count_q - AMT_BITS'(1);
                    if (count_q == AMT_BITS'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // busy/done decode straight from the state register, so they are mutually exclusive.
    assign bus.result = result_q;
    assign bus.busy   = (state_q == S_SHIFT);
    assign bus.done   = (state_q == S_DONE);
    assign bus.err    = err_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: expectations queued at issue, checked on each done pulse.
module tb_seq_shift_unit;
    logic clk;
    logic clr;

    seq_shift_unit_if #(.WIDTH(32)) bus_if ();

    seq_shift_unit #(.WIDTH(32), .AMT_BITS(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        err;
        int          cyc;
        int          busy_cycles;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt = 0;
    int   busy_run = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic op_is_legal(input logic [2:0] op);
`ifdef SEQ_SHIFT_ROTATE_EN
        return op <= 3'd4;
`else
        return op <= 3'd2;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] sb);
        int n;
        n = int'(sb[4:0]);
        if (!op_is_legal(op) || n == 0) return x;
        case (op)
            3'd0:    return x >> n;
            3'd1:    return $signed(x) >>> n;
            3'd2:    return x << n;
            3'd3:    return (x >> n) | (x << (32 - n));
            default: return (x << n) | (x >> (32 - n));
        endcase
    endfunction

    // Drive a request at a negedge, queue its expectation, return at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] operand, input logic [31:0] sb);
        exp_t e;
        int   n;
        n             = int'(sb[4:0]);
        e.op          = op;
        e.res         = model(op, operand, sb);
        e.err         = !op_is_legal(op);
        e.busy_cycles = (op_is_legal(op)) ? n : 0;
        e.cyc         = cyc_cnt + 1 + e.busy_cycles;
        sb_q.push_back(e);
        bus_if.start   = 1'b1;
        bus_if.op      = op;
        bus_if.operand = operand;
        bus_if.shiftBy = sb;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic finish_txn();
        bus_if.start = 1'b0;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check_eq("timeout_pending", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: one line per completed transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                busy_run = 0;
            end else begin
                if (bus_if.done) begin
                    check_eq("busy_with_done", 64'(bus_if.busy), 64'd0);
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_done", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        $display("txn op=%0d result=%08h err=%0b cycle=%0d busy_cycles=%0d",
                                 e.op, bus_if.result, bus_if.err, cyc_cnt, busy_run);
                        check_eq("result", 64'(bus_if.result), 64'(e.res));
                        check_eq("err", 64'(bus_if.err), 64'(e.err));
                        check_eq("done_cycle", 64'(cyc_cnt), 64'(e.cyc));
                        check_eq("busy_cycles", 64'(busy_run), 64'(e.busy_cycles));
                    end
                    busy_run = 0;
                end else if (bus_if.busy) begin
                    busy_run++;
                end
            end
        end
    end

    initial begin
        clr            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.op      = 3'd0;
        bus_if.operand = '0;
        bus_if.shiftBy = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_result", 64'(bus_if.result), 64'd0);
        check_eq("rst_busy", 64'(bus_if.busy), 64'd0);
        check_eq("rst_done", 64'(bus_if.done), 64'd0);
        check_eq("rst_err", 64'(bus_if.err), 64'd0);
        clr = 1'b0;
        @(negedge clk);

        // Abort mid-shift: asynchronous clear, no done afterwards.
        bus_if.start   = 1'b1;
        bus_if.op      = 3'd0;
        bus_if.operand = 32'hFFFF0000;
        bus_if.shiftBy = 32'd8;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_busy_before", 64'(bus_if.busy), 64'd1);
        #2 clr = 1'b1;
        #1;
        check_eq("abort_result", 64'(bus_if.result), 64'd0);
        check_eq("abort_busy", 64'(bus_if.busy), 64'd0);
        check_eq("abort_done", 64'(bus_if.done), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (12) @(negedge clk);

        send(3'd0, 32'h80000000, 32'd31);  finish_txn();
        send(3'd1, 32'h80000000, 32'd4);   finish_txn();
        send(3'd2, 32'h00000001, 32'h21);  finish_txn();
        send(3'd0, 32'h12345678, 32'd0);
        send(3'd4, 32'h80000001, 32'd1);   finish_txn();
        send(3'd3, 32'h00000001, 32'd1);   finish_txn();
        send(3'd7, 32'hCAFEF00D, 32'd5);   finish_txn();

        // Start while busy must be ignored.
        send(3'd0, 32'hF0F0F0F0, 32'd6);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.op      = 3'd2;
        bus_if.operand = 32'hDEADBEEF;
        bus_if.shiftBy = 32'd3;
        bus_if.start   = 1'b1;
        repeat (2) @(negedge clk);
        finish_txn();

        for (int i = 0; i < 6; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, $urandom);
            finish_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle shift/rotate engine placed in the ALU ahead of the Z result register. It shifts one bit position per clock, which lets the datapath trade the wide combinational shifter for a small iterative one. It uses a start/done handshake with the control unit, and its result feeds the Z-low input. The shift amount is taken from the low 5 bits of a 32-bit operand, matching the datapath's existing shift-amount convention.

## Interface
- WIDTH, 32, data width of operand and result
- AMT_BITS, 5, number of low shiftBy bits used; the rest are ignored
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when the unit can accept (IDLE or DONE)
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; others are illegal
- operand  in  WIDTH  value to shift
- shiftBy  in  32  shift amount; only [AMT_BITS-1:0] is used
- result  out  WIDTH  working/result register
- busy  out  1  high while the unit is in SHIFT
- done  out  1  one-cycle pulse; result is final while done is high
- err  out  1  registered; set on acceptance of an illegal/disabled op, cleared on the next acceptance

## Operation
- Reset value of every output is 0. Reset leaves the FSM in IDLE and the count at 0.
- Asserting clr at any time, including mid-shift, aborts immediately; no done pulse is produced for the aborted request.
- Acceptance: start=1 while state is IDLE or DONE. On the accepting edge:
  - result ← operand, op is latched, count ← shiftBy[AMT_BITS-1:0].
  - err ← (op illegal).
  - Next state is SHIFT if count≠0 and op is legal; otherwise DONE.
- States and transitions:
  - IDLE: waits for start.
  - SHIFT: each edge performs one 1-bit step on result and does count←count-1. When count==1 on an edge, that edge performs the last step and the next state is DONE.
  - DONE: done=1 for this cycle only. The next state is IDLE, or a new acceptance if start=1 (back-to-back).
- Behaviour of each op per step:
  - SHR: MSB←0.
  - SHRA: MSB←old MSB.
  - SHL: LSB←0.
  - ROR: MSB←old LSB.
  - ROL: LSB←old MSB.
- Illegal op: result stays equal to operand and err=1.
- start while in SHIFT is ignored and not queued. op, operand and shiftBy may change freely after acceptance.
- result shows intermediate values during SHIFT. It holds its final value from DONE until the next acceptance.
- shiftBy bits above AMT_BITS are ignored (e.g. 32 acts as 0 and 33 acts as 1).

## Timing
- Acceptance at edge k with legal amount n>0:
  - busy=1 after edges k … k+n-1.
  - done=1 for one cycle after edge k+n.
  - Latency is n cycles; the worst case is 31.
- Amount n=0 or illegal op: done=1 for one cycle after edge k (latency 1) and busy stays 0.
- Back-to-back: start held high during the DONE cycle is accepted at that edge, so there are no idle bubbles.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SEQ_SHIFT_ROTATE_EN defined: ROR and ROL are implemented as above.
- SEQ_SHIFT_ROTATE_EN undefined: op codes 011 and 100 are treated as illegal, with err=1, result=operand and latency 1. No rotate logic is synthesised.

## Test plan
- Reset mid-shift: start SHR, operand 0xFFFF0000, shiftBy 8; assert clr after 3 cycles → result=0, busy=0, done=0; no done pulse afterwards.
- SHR: operand 0x80000000, shiftBy 31 → done after 31 cycles, result 0x00000001, busy high for exactly 31 cycles.
- SHRA: operand 0x80000000, shiftBy 4 → result 0xF8000000 after 4 cycles. SHL: operand 0x00000001, shiftBy 0x00000021 (effective 1) → result 0x00000002 after 1 cycle.
- Zero amount and back-to-back:
  - shiftBy 0 with operand 0x12345678 → done on the next cycle, result 0x12345678, busy never high.
  - Then start ROL with operand 0x80000001, shiftBy 1, held through that DONE cycle → result 0x00000003.
- ROR: operand 0x00000001, shiftBy 1 → result 0x80000000 with SEQ_SHIFT_ROTATE_EN defined. Without the macro → err=1, result 0x00000001, latency 1.
- Start while busy: issue a second start with a different operand during SHIFT → it is ignored, and the first request's result and latency are unaffected.
